// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry {pc, instr} FIFO between instruction fetch and decode
//
// Purpose: a circular FIFO with valid/ready handshakes on both sides, a
// flush for branch/jump redirect, and a fixed NOP presented whenever empty.
// The read side is first-word-fall-through with no same-cycle bypass.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous clear, overrides push and pop
//   in_valid/in_ready   fetch-side handshake; in_ready = (count != DEPTH)
//   in_pc/in_instr      fetched pair, written on push
//   out_valid/out_ready decode-side handshake; out_valid = (count != 0)
//   out_pc/out_instr    head pair; 0 / NOP_INSTR when empty
//   count               occupancy, 0..DEPTH

module fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Storage is deliberately left out of reset: entries are only ever read
    // while count says they hold a pushed pair.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic push;
    logic pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;

    always_comb begin
        push     = in_valid  && in_ready  && !flush;
        pop      = out_valid && out_ready && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based model

module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_pc[$];
    logic [31:0] m_instr[$];

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_pc.size();
        check({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(n != DEPTH));
        check({tag, ".count"},     64'(count),     64'(n));
        check({tag, ".out_pc"},    64'(out_pc),    (n != 0) ? 64'(m_pc[0])    : 64'(0));
        check({tag, ".out_instr"}, 64'(out_instr), (n != 0) ? 64'(m_instr[0]) : 64'(NOP));
    endtask

    // Apply one cycle of stimulus, advance the model by the handshake rules,
    // then compare after the edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input string tag);
        bit do_push, do_pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        do_push = v && (m_pc.size() < DEPTH) && !fl;
        do_pop  = ordy && (m_pc.size() > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            m_pc.delete();
            m_instr.delete();
        end else begin
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_instr.pop_front());
            end
            if (do_push) begin
                m_pc.push_back(pc);
                m_instr.push_back(ins);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        // Reset then idle
        #1;
        check_all("reset_during");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all("reset_idle");
        check("reset_nop", 64'(out_instr), 64'(32'h13));

        // Fill without drain, then a refused fifth push
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, "fill");
        check("full_count", 64'(count), 64'(4));
        step(1'b1, 32'h110, 32'hA4, 1'b0, 1'b0, "full_refuse");
        check("full_head", 64'(out_pc), 64'(32'h100));

        // Drain in order
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
        check("drain_nop", 64'(out_instr), 64'(NOP));

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 1'b0, "stream");
            check("stream_count", 64'(count), 64'(1));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "stream_tail");

        // Flush with concurrent push and pop
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h280 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0, "pre_flush");
        step(1'b1, 32'h300, 32'hCC, 1'b1, 1'b1, "flush");
        check("flush_count", 64'(count), 64'(0));
        step(1'b1, 32'h400, 32'hD0, 1'b0, 1'b0, "post_flush");
        check("post_flush_head", 64'(out_pc), 64'(32'h400));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "post_flush_drain");

        // Async reset mid-stream
        step(1'b1, 32'h480, 32'hE0, 1'b0, 1'b0, "pre_rst");
        step(1'b1, 32'h484, 32'hE1, 1'b0, 1'b0, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        m_pc.delete();
        m_instr.delete();
        check_all("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 32'h500, 32'hF0, 1'b0, 1'b0, "post_rst");
        check("post_rst_head", 64'(out_pc), 64'(32'h500));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 31) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
